sprite_loader: RTL and testbench

//  Converts a raw 24-bit BMP byte stream (from the SD file reader) into the sprite texture

---
 rtl/sprite_loader_if.sv | 20 ++
 rtl/sprite_loader.sv | 164 ++++++++++++++++
 tb/tb_sprite_loader.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/sprite_loader_if.sv
// Byte-stream input and texture-write output bus of the sprite loader.
// The slave modport is the loader side; master is the SD reader / texture RAM side.
interface sprite_loader_if;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;
    logic        load_en;
    logic [12:0] load_addr;
    logic [15:0] load_data;

    modport master (
        output byte_data, byte_valid,
        input  byte_ready, load_en, load_addr, load_data
    );

    modport slave (
        input  byte_data, byte_valid,
        output byte_ready, load_en, load_addr, load_data
    );
endinterface

// File: rtl/sprite_loader.sv
// 24-bit BMP byte stream -> RGB565 texture writes, one sprite frame per start, rows un-flipped.
// Optional macro SPRITE_LOADER_KEY_EN: magenta 16'hF81F is written as transparency code 16'hFFFF.
module sprite_loader #(
    parameter int SPR_W     = 50,
    parameter int SPR_H     = 35,
    parameter int FRAMES    = 3,
    parameter int HDR_BYTES = 54
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      frame_sel,
    sprite_loader_if.slave  bus,
    output logic            busy,
    output logic            done,
    output logic            err
);
    localparam int ROW_PAD     = (4 - (3 * SPR_W) % 4) % 4;
    localparam int FRAME_WORDS = SPR_W * SPR_H;
    localparam int HW = (HDR_BYTES > 1) ? $clog2(HDR_BYTES) : 1;
    localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

    localparam logic [HW-1:0] HDR_LAST = HW'(HDR_BYTES - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(SPR_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(SPR_H - 1);
    localparam logic [1:0]    PAD_LAST = 2'(ROW_PAD - 1);
    localparam logic [12:0]   ROW_STEP = 13'(SPR_W);
    localparam logic [12:0]   TOP_OFS  = 13'((SPR_H - 1) * SPR_W);

    typedef enum logic [2:0] {IDLE, HDR, PIX, PAD, FIN} state_t;

    state_t         state;
    logic [HW-1:0]  hdr_cnt;
    logic [1:0]     phase;
    logic [CW-1:0]  col;
    logic [RW-1:0]  row;
    logic [1:0]     pad_cnt;
    logic [4:0]     b_hi;
    logic [5:0]     g_hi;
    logic [12:0]    line_addr;
    logic           byte_ready;
    logic           load_en;
    logic [12:0]    load_addr;
    logic [15:0]    load_data;

    logic           xfer;
    logic           sel_ok;
    logic           row_end;
    logic [12:0]    base_sel;
    logic [15:0]    pix_raw;
    logic [15:0]    pix;
    logic           unused_bits;

    assign bus.byte_ready = byte_ready;
    assign bus.load_en    = load_en;
    assign bus.load_addr  = load_addr;
    assign bus.load_data  = load_data;

    assign xfer     = bus.byte_valid & byte_ready;
    assign sel_ok   = int'(frame_sel) < FRAMES;
    assign base_sel = 13'(int'(frame_sel) * FRAME_WORDS);
    assign pix_raw  = {bus.byte_data[7:3], g_hi, b_hi};
    assign unused_bits = ^bus.byte_data[1:0];

`ifdef SPRITE_LOADER_KEY_EN
    assign pix = (pix_raw == 16'hF81F) ? 16'hFFFF : pix_raw;
`else
    assign pix = pix_raw;
`endif

    // A file row ends on its last pad byte, or on its last R byte when rows carry no padding.
    assign row_end = xfer & (((state == PIX) & (phase == 2'd2) & (col == COL_LAST) & (ROW_PAD == 0))
                           | ((state == PAD) & (pad_cnt == PAD_LAST)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            hdr_cnt    <= '0;
            phase      <= '0;
            col        <= '0;
            row        <= '0;
            pad_cnt    <= '0;
            b_hi       <= '0;
            g_hi       <= '0;
            line_addr  <= '0;
            byte_ready <= 1'b0;
            load_en    <= 1'b0;
            load_addr  <= '0;
            load_data  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            load_en <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    if (sel_ok) begin
                        state      <= HDR;
                        busy       <= 1'b1;
                        byte_ready <= 1'b1;
                        hdr_cnt    <= '0;
                        phase      <= '0;
                        col        <= '0;
                        row        <= '0;
                        pad_cnt    <= '0;
                        // BMP stores the bottom row first, so file row 0 lands on the last sprite line.
                        line_addr  <= base_sel + TOP_OFS;
                    end else begin
                        err <= 1'b1;
                    end
                end
                HDR: if (xfer) begin
                    if (hdr_cnt == HDR_LAST) state <= PIX;
                    else                     hdr_cnt <= hdr_cnt + 1'b1;
                end
                PIX: if (xfer) begin
                    case (phase)
                        2'd0: begin
                            b_hi  <= bus.byte_data[7:3];
                            phase <= 2'd1;
                        end
                        2'd1: begin
                            g_hi  <= bus.byte_data[7:2];
                            phase <= 2'd2;
                        end
                        default: begin
                            phase     <= 2'd0;
                            load_en   <= 1'b1;
                            load_data <= pix;
                            load_addr <= line_addr + 13'(col);
                            if (col == COL_LAST) begin
                                col <= '0;
                                if (ROW_PAD != 0) state <= PAD;
                            end else begin
                                col <= col + 1'b1;
                            end
                        end
                    endcase
                end
                PAD: if (xfer) begin
                    pad_cnt <= (pad_cnt == PAD_LAST) ? 2'd0 : pad_cnt + 1'b1;
                end
                FIN: state <= IDLE;
                default: state <= IDLE;
            endcase

            if (row_end) begin
                if (row == ROW_LAST) begin
                    state      <= FIN;
                    busy       <= 1'b0;
                    done       <= 1'b1;
                    byte_ready <= 1'b0;
                end else begin
                    row       <= row + 1'b1;
                    line_addr <= line_addr - ROW_STEP;
                    state     <= PIX;
                end
            end
        end
    end
endmodule

// File: tb/tb_sprite_loader.sv
// Scoreboard bench for sprite_loader: expected texture writes are queued as bytes are driven
// and compared as load_en strobes appear.
module tb_sprite_loader;
    localparam int SPR_W = 50, SPR_H = 35, HDR = 54, PAD_N = 2;
`ifdef SPRITE_LOADER_KEY_EN
    localparam logic [15:0] EXP_KEY = 16'hFFFF;
`else
    localparam logic [15:0] EXP_KEY = 16'hF81F;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] frame_sel = 2'd0;
    logic       busy, done, err;

    sprite_loader_if bus();

    sprite_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .frame_sel(frame_sel),
        .bus(bus.slave), .busy(busy), .done(done), .err(err)
    );

    always #10 clk = ~clk;

    typedef struct packed { logic [12:0] addr; logic [15:0] data; } wr_t;
    wr_t         exp_q[$];
    wr_t         exp_w;
    logic [12:0] addr_log[$];
    logic [15:0] data_log[$];
    int          tests = 0, fails = 0, done_cnt = 0, err_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] conv(input logic [7:0] b, input logic [7:0] g, input logic [7:0] r);
        logic [15:0] p;
        p = {r[7:3], g[7:2], b[7:3]};
`ifdef SPRITE_LOADER_KEY_EN
        if (p == 16'hF81F) p = 16'hFFFF;
`endif
        return p;
    endfunction

    always @(negedge clk) begin
        if (bus.load_en === 1'b1) begin
            addr_log.push_back(bus.load_addr);
            data_log.push_back(bus.load_data);
            if (exp_q.size() == 0) begin
                chk("unexp_wr", {19'b0, bus.load_addr}, 32'hFFFF_FFFF);
            end else begin
                exp_w = exp_q.pop_front();
                chk("wr_addr", {19'b0, bus.load_addr}, {19'b0, exp_w.addr});
                chk("wr_data", {16'b0, bus.load_data}, {16'b0, exp_w.data});
            end
        end
        if (done === 1'b1) done_cnt++;
        if (err === 1'b1) err_cnt++;
    end

    task automatic send_byte(input logic [7:0] d, input int gap);
        int t;
        repeat (gap) @(negedge clk);
        bus.byte_valid = 1'b1;
        bus.byte_data  = d;
        t = 0;
        while (bus.byte_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("rdy_timeout", t, 0);
        @(negedge clk);
        bus.byte_valid = 1'b0;
    endtask

    task automatic pulse_start(input logic [1:0] sel);
        start = 1'b1;
        frame_sel = sel;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_pix(input int sel, input int r, input int c,
                            input logic [7:0] b, input logic [7:0] g, input logic [7:0] rr, input int max_gap);
        wr_t w;
        w.addr = 13'(sel * SPR_W * SPR_H + (SPR_H - 1 - r) * SPR_W + c);
        w.data = conv(b, g, rr);
        exp_q.push_back(w);
        send_byte(b,  $urandom_range(max_gap));
        send_byte(g,  $urandom_range(max_gap));
        send_byte(rr, $urandom_range(max_gap));
    endtask

    task automatic send_hdr(input int max_gap);
        for (int i = 0; i < HDR; i++) send_byte(8'($urandom), $urandom_range(max_gap));
    endtask

    task automatic send_row(input int sel, input int r, input int max_gap, input bit poke);
        for (int c = 0; c < SPR_W; c++) begin
            if (r == 0 && c == 0 && sel == 0)      send_pix(sel, r, c, 8'hFF, 8'h00, 8'hFF, max_gap);
            else if (r == 0 && c == 0 && sel == 1) send_pix(sel, r, c, 8'h00, 8'hFF, 8'hFF, max_gap);
            else send_pix(sel, r, c, 8'($urandom), 8'($urandom), 8'($urandom), max_gap);
            if (poke && c == 7) pulse_start(2'd3);
        end
    endtask

    task automatic send_pad(input int max_gap);
        for (int p = 0; p < PAD_N; p++) send_byte(8'($urandom), $urandom_range(max_gap));
    endtask

    initial begin
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'b0, bus.byte_ready}, 0);
        chk("rst_load_en", {31'b0, bus.load_en}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_err", {31'b0, err}, 0);
        bus.byte_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", {31'b0, bus.byte_ready}, 0);

        // Frame 1: first pixel, full row 0 with pad, one pixel of row 1, then abort by reset.
        pulse_start(2'd1);
        chk("busy_start", {31'b0, busy}, 1);
        send_hdr(1);
        chk("hdr_no_wr", addr_log.size(), 0);
        send_row(1, 0, 1, 1'b0);
        send_pad(1);
        @(negedge clk);
        chk("row0_wr_cnt", addr_log.size(), SPR_W);
        chk("f1_first_addr", {19'b0, addr_log[0]}, 3450);
        chk("f1_first_data", {16'b0, data_log[0]}, 32'hFFE0);
        send_pix(1, 1, 0, 8'h12, 8'h34, 8'h56, 0);
        repeat (2) @(negedge clk);
        chk("pad_wr_cnt", addr_log.size(), SPR_W + 1);
        chk("row1_addr", {19'b0, addr_log[SPR_W]}, 3400);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus.byte_valid = 1'b1;
        repeat (5) @(negedge clk);
        bus.byte_valid = 1'b0;
        chk("abort_busy", {31'b0, busy}, 0);
        chk("abort_ready", {31'b0, bus.byte_ready}, 0);
        chk("abort_wr_cnt", addr_log.size(), SPR_W + 1);
        chk("abort_q_empty", exp_q.size(), 0);

        // Frame 0: full frame with random gaps; a bad start while busy must be ignored.
        addr_log.delete();
        data_log.delete();
        done_cnt = 0;
        err_cnt  = 0;
        pulse_start(2'd0);
        send_hdr(3);
        for (int r = 0; r < SPR_H; r++) begin
            send_row(0, r, 3, r == 10);
            if (r == SPR_H - 1) begin
                send_byte(8'($urandom), $urandom_range(3));
                send_byte(8'($urandom), $urandom_range(3));
                chk("done_after_pad", {31'b0, done}, 1);
                chk("busy_at_done", {31'b0, busy}, 0);
            end else begin
                send_pad(3);
            end
        end
        @(negedge clk);
        chk("done_one_cycle", {31'b0, done}, 0);
        chk("ready_after_done", {31'b0, bus.byte_ready}, 0);
        repeat (3) @(negedge clk);
        chk("frame_wr_cnt", addr_log.size(), SPR_W * SPR_H);
        chk("frame_last_addr", {19'b0, addr_log[addr_log.size() - 1]}, 49);
        chk("frame_done_cnt", done_cnt, 1);
        chk("busy_start_no_err", err_cnt, 0);
        chk("frame_q_empty", exp_q.size(), 0);
        chk("key_pix_addr", {19'b0, addr_log[0]}, 1700);
        chk("key_pix_data", {16'b0, data_log[0]}, {16'b0, EXP_KEY});

        // Out-of-range frame select.
        addr_log.delete();
        err_cnt = 0;
        pulse_start(2'd3);
        chk("bad_sel_err", {31'b0, err}, 1);
        chk("bad_sel_busy", {31'b0, busy}, 0);
        bus.byte_valid = 1'b1;
        @(negedge clk);
        chk("bad_sel_err_clr", {31'b0, err}, 0);
        repeat (4) @(negedge clk);
        chk("bad_sel_ready", {31'b0, bus.byte_ready}, 0);
        bus.byte_valid = 1'b0;
        @(negedge clk);
        chk("bad_sel_no_wr", addr_log.size(), 0);
        chk("bad_sel_err_cnt", err_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
